// File: rtl/uart_pixel_packer.sv
// Packs UART bytes (high byte first) into RGB565 pixels for the SDRAM write FIFO,
// tracking frame position and recovering byte alignment with an inter-byte timeout.
module uart_pixel_packer #(
   parameter int unsigned FRAME_PIXELS   = 307200,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned CNT_W          = 19
) (
   input  logic             mclk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_done,
   input  logic             fifo_full,
   output logic             pix_wr_en,
   output logic [15:0]      pix_wr_data,
   output logic [CNT_W-1:0] pix_cnt,
   output logic             frame_start,
   output logic             frame_done,
   output logic             timeout,
   output logic             overflow
);

   localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

   state_e          state;
   logic [7:0]      high_byte;
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         state       <= StIdle;
         high_byte   <= 8'h00;
         to_cnt      <= '0;
         pix_wr_en   <= 1'b0;
         pix_wr_data <= 16'h0000;
         pix_cnt     <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         timeout     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pix_wr_en   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         timeout     <= 1'b0;
         // The final count of a frame is shown for exactly one cycle.
         if (frame_done) pix_cnt <= '0;

         unique case (state)
            StIdle: begin
               to_cnt <= '0;
               if (rx_done) begin
                  high_byte   <= rx_data;
                  frame_start <= 1'b1;
                  state       <= StLow;
               end
            end
            StLow, StHigh: begin
               if (rx_done) begin
                  to_cnt <= '0;
                  if (state == StHigh) begin
                     high_byte <= rx_data;
                     state     <= StLow;
                  end else begin
                     // Dropped pixels still count so frame geometry is preserved.
                     pix_wr_data <= {high_byte, rx_data};
                     pix_wr_en   <= ~fifo_full;
                     if (fifo_full) overflow <= 1'b1;
                     pix_cnt <= pix_cnt + 1'b1;
                     if (pix_cnt == LAST_PIX) begin
                        frame_done <= 1'b1;
                        state      <= StIdle;
                     end else begin
                        state <= StHigh;
                     end
                  end
               end else if (to_cnt == TO_LAST) begin
                  state     <= StIdle;
                  pix_cnt   <= '0;
                  high_byte <= 8'h00;
                  to_cnt    <= '0;
                  timeout   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Self-checking bench for uart_pixel_packer: directed vector table, hand-written
// corner sequences, and randomized bursts checked against a byte-counting model.
module tb_uart_pixel_packer;

   localparam int unsigned FP = 4;
   localparam int unsigned TO = 100;
   localparam int unsigned CW = 8;

   logic          mclk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_done = 1'b0;
   logic          fifo_full = 1'b0;
   logic          pix_wr_en;
   logic [15:0]   pix_wr_data;
   logic [CW-1:0] pix_cnt;
   logic          frame_start, frame_done, timeout, overflow;

   uart_pixel_packer #(
      .FRAME_PIXELS  (FP),
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CW)
   ) dut (
      .mclk       (mclk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .fifo_full  (fifo_full),
      .pix_wr_en  (pix_wr_en),
      .pix_wr_data(pix_wr_data),
      .pix_cnt    (pix_cnt),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .timeout    (timeout),
      .overflow   (overflow)
   );

   always #5 mclk = ~mclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: a frame is a run of bytes; every second byte completes a pixel.
   bit         m_we, m_fs, m_fd, m_to, m_ovf;
   logic [15:0] m_data;
   int         m_cnt;
   bit         active;
   int         nbytes, idle;
   logic [7:0] hi;

   bit          prev_we;
   int          wr_evt, fs_evt, fd_evt, to_evt;
   logic [15:0] wq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack(input bit we, input logic [15:0] d, input logic [7:0] c,
                                        input bit fs, input bit fd, input bit to, input bit ov);
      logic [63:0] v;
      v = '0;
      v[28:0] = {we, d, c, fs, fd, to, ov};
      return v;
   endfunction

   function automatic logic [63:0] dut_vec();
      return pack(pix_wr_en, pix_wr_data, pix_cnt, frame_start, frame_done, timeout, overflow);
   endfunction

   task automatic model_step(input bit r, input bit rd, input logic [7:0] d, input bit ff);
      bit was_done;
      was_done = m_fd;
      m_we = 0; m_fs = 0; m_fd = 0; m_to = 0;
      if (!r) begin
         m_data = 16'h0; m_cnt = 0; m_ovf = 0;
         active = 0; nbytes = 0; idle = 0; hi = 8'h0;
         return;
      end
      if (was_done) m_cnt = 0;
      if (rd) begin
         idle = 0;
         if (!active) begin
            active = 1; nbytes = 1; hi = d; m_fs = 1;
         end else begin
            nbytes++;
            if (nbytes % 2 == 1) begin
               hi = d;
            end else begin
               m_data = {hi, d};
               if (ff) m_ovf = 1;
               else    m_we = 1;
               m_cnt = nbytes / 2;
               if (m_cnt == FP) begin
                  m_fd = 1; active = 0;
               end
            end
         end
      end else if (active) begin
         idle++;
         if (idle == TO) begin
            m_to = 1; active = 0; m_cnt = 0; idle = 0;
         end
      end
   endtask

   task automatic tick(input bit r, input bit rd, input logic [7:0] d, input bit ff);
      rst_n = r; rx_done = rd; rx_data = d; fifo_full = ff;
      @(posedge mclk);
      #1;
      model_step(r, rd, d, ff);
      chk("cycle_outputs", dut_vec(), pack(m_we, m_data, 8'(m_cnt), m_fs, m_fd, m_to, m_ovf));
      chk("wr_en_gap", {63'b0, prev_we & pix_wr_en}, 64'd0);
      prev_we = pix_wr_en;
      if (pix_wr_en) begin
         wr_evt++;
         wq.push_back(pix_wr_data);
      end
      if (frame_start) fs_evt++;
      if (frame_done)  fd_evt++;
      if (timeout)     to_evt++;
   endtask

   task automatic byte_in(input logic [7:0] d, input bit ff);
      tick(1'b1, 1'b1, d, ff);
   endtask

   task automatic idle_tick();
      tick(1'b1, 1'b0, 8'($urandom), 1'($urandom));
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      wr_evt = 0; fs_evt = 0; fd_evt = 0; to_evt = 0;
      wq.delete();
   endtask

   typedef struct {
      bit          r, rd;
      logic [7:0]  d;
      bit          ff;
      bit          we;
      logic [15:0] data;
      logic [7:0]  cnt;
      bit          fs, fd, to, ov;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int k;
      vecs[0]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 8'd0, 0, 0, 0, 0};
      vecs[1]  = '{1, 0, 8'h00, 0, 0, 16'h0000, 8'd0, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 8'h12, 0, 0, 16'h0000, 8'd0, 1, 0, 0, 0};
      vecs[3]  = '{1, 1, 8'h34, 0, 1, 16'h1234, 8'd1, 0, 0, 0, 0};
      vecs[4]  = '{1, 1, 8'h56, 0, 0, 16'h1234, 8'd1, 0, 0, 0, 0};
      vecs[5]  = '{1, 1, 8'h78, 0, 1, 16'h5678, 8'd2, 0, 0, 0, 0};
      vecs[6]  = '{1, 1, 8'h9A, 0, 0, 16'h5678, 8'd2, 0, 0, 0, 0};
      vecs[7]  = '{1, 1, 8'hBC, 0, 1, 16'h9ABC, 8'd3, 0, 0, 0, 0};
      vecs[8]  = '{1, 1, 8'hDE, 0, 0, 16'h9ABC, 8'd3, 0, 0, 0, 0};
      vecs[9]  = '{1, 1, 8'hF0, 0, 1, 16'hDEF0, 8'd4, 0, 1, 0, 0};
      vecs[10] = '{1, 0, 8'h00, 0, 0, 16'hDEF0, 8'd0, 0, 0, 0, 0};
      vecs[11] = '{1, 0, 8'h00, 0, 0, 16'hDEF0, 8'd0, 0, 0, 0, 0};

      for (int i = 0; i < 12; i++) begin
         tick(vecs[i].r, vecs[i].rd, vecs[i].d, vecs[i].ff);
         chk($sformatf("vec%0d", i), dut_vec(),
             pack(vecs[i].we, vecs[i].data, vecs[i].cnt, vecs[i].fs, vecs[i].fd, vecs[i].to,
                  vecs[i].ov));
      end

      // Back-to-back frames, second frame's first byte right behind frame_done.
      do_reset();
      for (int i = 1; i <= 16; i++) byte_in(8'(i), 1'b0);
      for (int i = 0; i < 3; i++) idle_tick();
      chk("b2b_writes", 64'(wr_evt), 64'd8);
      chk("b2b_starts", 64'(fs_evt), 64'd2);
      chk("b2b_dones", 64'(fd_evt), 64'd2);
      chk("b2b_timeouts", 64'(to_evt), 64'd0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("b2b_data%0d", i), 64'(wq[i]), 64'({8'(2*i+1), 8'(2*i+2)}));

      // Timeout after a dangling high byte.
      do_reset();
      byte_in(8'hAA, 1'b0);
      byte_in(8'hBB, 1'b0);
      byte_in(8'hCC, 1'b0);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         idle_tick();
         if (timeout) begin
            k = i;
            break;
         end
      end
      chk("timeout_delay", 64'(k), 64'd100);
      chk("timeout_writes", 64'(wr_evt), 64'd1);
      chk("timeout_data", 64'(wq[0]), 64'h0000_AABB);
      byte_in(8'h11, 1'b0);
      chk("post_to_start", 64'(frame_start), 64'd1);
      byte_in(8'h22, 1'b0);
      chk("post_to_pixel", dut_vec(), pack(1, 16'h1122, 8'd1, 0, 0, 0, 0));

      // Byte arriving exactly on the expiry cycle wins.
      do_reset();
      byte_in(8'hAA, 1'b0);
      for (int i = 0; i < 99; i++) idle_tick();
      byte_in(8'hBB, 1'b0);
      chk("coincide_write", dut_vec(), pack(1, 16'hAABB, 8'd1, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++) idle_tick();
      byte_in(8'hCC, 1'b0);
      byte_in(8'hDD, 1'b0);
      chk("coincide_continue", 64'(pix_cnt), 64'd2);
      chk("coincide_no_to", 64'(to_evt), 64'd0);

      // FIFO full on second pixel: drop but keep counting; overflow is sticky.
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         byte_in(8'(i), i == 4);
         if (i == 4) chk("ovf_drop", dut_vec(), pack(0, 16'h0304, 8'd2, 0, 0, 0, 1));
      end
      chk("ovf_done", 64'(fd_evt), 64'd1);
      chk("ovf_writes", 64'(wr_evt), 64'd3);
      byte_in(8'h55, 1'b0);
      byte_in(8'h66, 1'b0);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // Reset mid-frame discards the pending high byte.
      do_reset();
      byte_in(8'h12, 1'b0);
      byte_in(8'h34, 1'b0);
      byte_in(8'h56, 1'b0);
      tick(1'b0, 1'b1, 8'h99, 1'b0);
      chk("midreset_zero", dut_vec(), 64'd0);
      idle_tick();
      byte_in(8'h77, 1'b0);
      chk("midreset_start", 64'(frame_start), 64'd1);
      byte_in(8'h88, 1'b0);
      chk("midreset_pixel", dut_vec(), pack(1, 16'h7788, 8'd1, 0, 0, 0, 0));

      // Randomized bursts with occasional long gaps, FIFO-full and resets.
      do_reset();
      for (int b = 0; b < 80; b++) begin
         int nb;
         nb = $urandom_range(1, 12);
         for (int j = 0; j < nb; j++) begin
            byte_in(8'($urandom), $urandom_range(0, 9) == 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_tick();
         end
         if ($urandom_range(0, 3) == 0) begin
            for (int g = $urandom_range(96, 104); g > 0; g--) idle_tick();
         end
         if ($urandom_range(0, 29) == 0) tick(1'b0, 1'b0, 8'h00, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
